adventure_move_scheduler: RTL and testbench
===========================================

// Module: adventure_move_scheduler
// PURPOSE
//  Sits between the raw N/S/E/W push-buttons and the adventure-game top level (room FSM + sword FSM).
//  Edge-detects presses and queues them in a small FIFO.
//  Issues exactly one single-cycle one-hot move to the game FSMs, with a programmable settle gap between moves.
//  Freezes all moves once the game reports win or death.
// PARAMETERS
//  DEPTH       4  move FIFO entries; power of 2, >=2
//  GAP_CYCLES  1  idle cycles forced after each issued move, 0..15
// PORTS
//  clk         in   1  single clock; all logic on rising edge
//  reset       in   1  synchronous, active-high; sampled on clk rising edge
//  n_btn       in   1  raw north button (level)
//  s_btn       in   1  raw south button
//  e_btn       in   1  raw east button
//  w_btn       in   1  raw west button
//  win         in   1  game win flag from game top
//  d           in   1  game death flag from game top
//  n           out  1  move north to game, 1-cycle pulse
//  s           out  1  move south to game, 1-cycle pulse
//  e           out  1  move east to game, 1-cycle pulse
//  w           out  1  move west to game, 1-cycle pulse
//  busy        out  1  FIFO non-empty or state != IDLE/HALT
//  lost_press  out  1  1-cycle pulse: a press was dropped
//  game_over   out  1  sticky; high in HALT
//  move_count  out  8  moves issued, saturating (only with MOVE_COUNT_EN)
// BEHAVIOUR
//  Reset:
//   - all outputs 0, FIFO empty, state IDLE, btn_q = 0.
//   - Reset wins over every other event, including mid-ISSUE/GAP.
//  Edge detect:
//   - rise[i] = btn[i] & ~btn_q[i]; btn_q registered each cycle.
//   - Held buttons never repeat.
//  Enqueue:
//   - Exactly one rise bit set -> push 2-bit dir code (N=0,S=1,E=2,W=3).
//   - More than one set (chord) -> push nothing, pulse lost_press next cycle.
//   - Push while full with no pop in the same cycle -> dropped, lost_press pulsed.
//   - Push while full with a same-cycle pop -> accepted.
//   - No bypass: a push into an empty FIFO is issued at the earliest one edge later.
//  FSM (registered outputs):
//   - IDLE: FIFO non-empty -> pop, load one-hot dir register, go to ISSUE.
//   - ISSUE: exactly one of n/s/e/w high for one cycle. Exit to GAP if GAP_CYCLES>0, else IDLE.
//   - GAP: outputs 0; down-counter from GAP_CYCLES-1; at 0 go to IDLE.
//   - HALT: outputs 0, game_over=1, FIFO flushed; pushes ignored, no lost_press. Only reset exits.
//  Game over:
//   - win|d sampled high in any state -> HALT at the next edge.
//   - Game over has priority over pop and over push.
//   - A move in ISSUE that same cycle still completes its single cycle.
//  Timing:
//   - Press sampled at edge k -> move output high from edge k+1 to k+2.
//   - Back-to-back queued moves are spaced GAP_CYCLES+2 cycles apart.
//  n/s/e/w are never simultaneously high, and never high two consecutive cycles.
// CONFIGURATION
//  MOVE_COUNT_EN defined:
//   - move_count port present.
//   - Increments on every ISSUE cycle, saturates at 255, reset to 0, holds in HALT.
//  MOVE_COUNT_EN undefined: port and counter absent; all other behaviour identical.
// STRUCTURE
//  adventure_pkg:
//   - dir_e enum {DIR_N, DIR_S, DIR_E, DIR_W} (2-bit).
//   - sched_state_e {IDLE, ISSUE, GAP, HALT}.
//   - function dir_to_onehot(dir_e) -> logic [3:0] {n,s,e,w}.
//   - localparam MOVE_CNT_W = 8.
//  Sub-module move_fifo #(DEPTH, W=2):
//   - sync FIFO with push/pop/full/empty/flush.
//   - Pointers are $clog2(DEPTH)+1 bits wide, wrap-around by MSB compare.
// TESTING
//  1. Reset 1 cycle, e_btn rises -> e=1 exactly one cycle, 1 edge after sample; busy falls after GAP.
//  2. Press e, s, w, e in consecutive cycles (GAP=1) -> e,s,w,e pulses 3 cycles apart, in order, no lost_press.
//  3. DEPTH=4, 6 single presses while in GAP -> 4 issued, lost_press pulses twice, order preserved.
//  4. n_btn and e_btn rise same cycle -> no move, lost_press=1 one cycle; FIFO count unchanged.
//  5. d=1 while 2 moves queued -> HALT next edge, game_over=1, no further pulses; later presses ignored.
//  6. reset during GAP with FIFO non-empty -> outputs 0 next edge, no queued move ever issued; move_count=0 when MOVE_COUNT_EN.

Source files
------------

// File: rtl/adventure_pkg.sv
// adventure_pkg: shared move/direction types and the scheduler state encoding.
package adventure_pkg;
    typedef enum logic [1:0] {DIR_N, DIR_S, DIR_E, DIR_W} dir_e;
    typedef enum logic [1:0] {IDLE, ISSUE, GAP, HALT} sched_state_e;
    localparam int MOVE_CNT_W = 8;

    // Bit order is {n,s,e,w}, so DIR_N lands on bit 3.
    function automatic logic [3:0] dir_to_onehot(input dir_e dir);
        return 4'b1000 >> dir;
    endfunction
endpackage

// File: rtl/move_fifo.sv
// move_fifo: small synchronous FIFO with flush; pointers carry one extra wrap bit.
module move_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_q, wr_d, rd_q, rd_d;
    logic [W-1:0] mem_q [DEPTH];
    logic         do_push, do_pop;

    always_comb begin
        empty   = wr_q == rd_q;
        full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
        do_pop  = pop && !empty;
        // A pop in the same cycle frees the slot a push into a full FIFO needs.
        do_push = push && (!full || do_pop);
        wr_d    = flush ? '0 : wr_q + {{AW{1'b0}}, do_push};
        rd_d    = flush ? '0 : rd_q + {{AW{1'b0}}, do_pop};
        dout    = mem_q[rd_q[AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush)
            mem_q[wr_q[AW-1:0]] <= din;
    end
endmodule

// File: rtl/adventure_move_scheduler.sv
// adventure_move_scheduler: edge-detects N/S/E/W presses, queues them and issues spaced one-hot moves.
// Optional MOVE_COUNT_EN adds a saturating move_count output.
module adventure_move_scheduler
    import adventure_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int GAP_CYCLES = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic n_btn,
    input  logic s_btn,
    input  logic e_btn,
    input  logic w_btn,
    input  logic win,
    input  logic d,
    output logic n,
    output logic s,
    output logic e,
    output logic w,
    output logic busy,
    output logic lost_press,
    output logic game_over
`ifdef MOVE_COUNT_EN
    ,
    output logic [MOVE_CNT_W-1:0] move_count
`endif
);
    localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);

    sched_state_e state_q, state_d;
    logic [3:0]   btn, btn_q, btn_d, rise, move_q, move_d, gap_q, gap_d;
    logic         lost_q, lost_d;
    logic         single, chord, stop, pop, push;
    logic         fifo_full, fifo_empty;
    logic [1:0]   fifo_dout;
    dir_e         push_dir;

    assign btn = {n_btn, s_btn, e_btn, w_btn};

    move_fifo #(.DEPTH(DEPTH), .W(2)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (stop),
        .din   (push_dir),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        btn_d    = btn;
        rise     = btn & ~btn_q;
        single   = $onehot(rise);
        chord    = (rise != 4'd0) && !single;
        push_dir = rise[3] ? DIR_N : rise[2] ? DIR_S : rise[1] ? DIR_E : DIR_W;
        // Game over (or already halted) blocks pops, pushes and drop reporting.
        stop     = win || d || (state_q == HALT);
        pop      = (state_q == IDLE) && !fifo_empty && !stop;
        push     = single && !stop;
        lost_d   = !stop && (chord || (single && fifo_full && !pop));
        state_d  = state_q;
        move_d   = '0;
        gap_d    = gap_q;
        unique case (state_q)
            IDLE: begin
                state_d = pop ? ISSUE : IDLE;
                move_d  = pop ? dir_to_onehot(dir_e'(fifo_dout)) : 4'd0;
            end
            ISSUE: begin
                state_d = (GAP_CYCLES > 0) ? GAP : IDLE;
                gap_d   = GAP_LOAD;
            end
            GAP: begin
                state_d = (gap_q == 4'd0) ? IDLE : GAP;
                gap_d   = (gap_q == 4'd0) ? 4'd0 : gap_q - 4'd1;
            end
            HALT: state_d = HALT;
        endcase
        if (win || d)
            state_d = HALT;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            btn_q   <= '0;
            move_q  <= '0;
            gap_q   <= '0;
            lost_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            btn_q   <= btn_d;
            move_q  <= move_d;
            gap_q   <= gap_d;
            lost_q  <= lost_d;
        end
    end

    assign {n, s, e, w} = move_q;
    assign busy         = !fifo_empty || (state_q == ISSUE) || (state_q == GAP);
    assign lost_press   = lost_q;
    assign game_over    = state_q == HALT;

`ifdef MOVE_COUNT_EN
    logic [MOVE_CNT_W-1:0] cnt_q, cnt_d;

    always_comb
        cnt_d = ((state_q == ISSUE) && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;

    always_ff @(posedge clk) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign move_count = cnt_q;
`endif
endmodule

// File: tb/tb_adventure_move_scheduler.sv
// tb_adventure_move_scheduler: directed stimulus, queue-based reference model checked every cycle.
module tb_adventure_move_scheduler;
    localparam int DEPTH = 4;
    localparam int GAP   = 1;

    logic clk = 1'b0, reset = 1'b1;
    logic n_btn = 1'b0, s_btn = 1'b0, e_btn = 1'b0, w_btn = 1'b0, win = 1'b0, d = 1'b0;
    logic n, s, e, w, busy, lost_press, game_over;
`ifdef MOVE_COUNT_EN
    logic [7:0] move_count;
`endif

    always #5 clk = ~clk;

    adventure_move_scheduler #(.DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
        .clk        (clk),
        .reset      (reset),
        .n_btn      (n_btn),
        .s_btn      (s_btn),
        .e_btn      (e_btn),
        .w_btn      (w_btn),
        .win        (win),
        .d          (d),
        .n          (n),
        .s          (s),
        .e          (e),
        .w          (w),
        .busy       (busy),
        .lost_press (lost_press),
        .game_over  (game_over)
`ifdef MOVE_COUNT_EN
        ,
        .move_count (move_count)
`endif
    );

    int checks = 0, errors = 0, moves_seen = 0, lost_seen = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a queue of pending directions plus a cooldown that
    // allows the next issue only GAP+2 edges after the previous one.
    int         q[$];
    int         m_wait = 0, m_cnt = 0;
    logic [3:0] m_prev = '0, m_move = '0;
    logic       m_lost = 1'b0, m_halt = 1'b0;

    initial forever begin
        logic [3:0] r;
        int         nr, dir;
        @(posedge clk);
        r      = {n_btn, s_btn, e_btn, w_btn} & ~m_prev;
        m_prev = reset ? 4'd0 : {n_btn, s_btn, e_btn, w_btn};
        if (reset) begin
            q.delete();
            m_wait = 0; m_cnt = 0; m_move = '0; m_lost = 1'b0; m_halt = 1'b0;
        end else begin
            if (m_move != 0 && m_cnt < 255) m_cnt++;
            m_move = '0;
            m_lost = 1'b0;
            if (!m_halt) begin
                if (win || d) begin
                    m_halt = 1'b1;
                    q.delete();
                end else begin
                    if (m_wait == 0 && q.size() > 0) begin
                        m_move = 4'b1000 >> q.pop_front();
                        m_wait = GAP + 1;
                    end else if (m_wait > 0) begin
                        m_wait--;
                    end
                    nr = $countones(r);
                    if (nr > 1) m_lost = 1'b1;
                    else if (nr == 1) begin
                        dir = 0;
                        for (int k = 0; k < 4; k++) if (r[3-k]) dir = k;
                        if (q.size() < DEPTH) q.push_back(dir);
                        else m_lost = 1'b1;
                    end
                end
            end
        end
        #1;
        moves_seen += int'(n | s | e | w);
        lost_seen  += int'(lost_press);
        chk("moves", {28'd0, n, s, e, w}, {28'd0, m_move});
        chk("lost_press", {31'd0, lost_press}, {31'd0, m_lost});
        chk("game_over", {31'd0, game_over}, {31'd0, m_halt});
        chk("busy", {31'd0, busy}, {31'd0, !m_halt && (q.size() > 0 || m_wait > 0)});
`ifdef MOVE_COUNT_EN
        chk("move_count", {24'd0, move_count}, m_cnt);
`endif
    end

    task automatic idle(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic setb(input logic [3:0] b);
        {n_btn, s_btn, e_btn, w_btn} = b;
        @(negedge clk);
    endtask

    initial begin
        int mv, ls;
        logic [3:0] b;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        idle(3);

        // single east press: issued one edge after the sampling edge
        setb(4'b0010);
        chk("t1_e_at_sample", {31'd0, e}, 0);
        setb(4'b0000);
        chk("t1_e_pulse", {31'd0, e}, 1);
        idle(1);
        chk("t1_e_low", {31'd0, e}, 0);
        chk("t1_busy_gap", {31'd0, busy}, 1);
        idle(1);
        chk("t1_busy_idle", {31'd0, busy}, 0);

        // e, s, w, e on consecutive cycles
        mv = moves_seen; ls = lost_seen;
        setb(4'b0010); setb(4'b0100); setb(4'b0001); setb(4'b0010); setb(4'b0000);
        idle(15);
        chk("t2_moves", moves_seen - mv, 4);
        chk("t2_lost", lost_seen - ls, 0);

        // chord
        mv = moves_seen; ls = lost_seen;
        setb(4'b1010); setb(4'b0000);
        idle(3);
        chk("t4_lost", lost_seen - ls, 1);
        chk("t4_moves", moves_seen - mv, 0);
        chk("t4_busy", {31'd0, busy}, 0);

        // overflow: nine presses on consecutive cycles
        mv = moves_seen; ls = lost_seen;
        for (int i = 0; i < 9; i++) begin
            b = 4'b1000 >> (i % 4);
            setb(b);
        end
        setb(4'b0000);
        idle(25);
        chk("t3_lost", lost_seen - ls, 2);
        chk("t3_moves", moves_seen - mv, 7);

        // drive the move counter past saturation
        mv = moves_seen;
        for (int i = 0; i < 260; i++) begin
            b = 4'b1000 >> (i % 4);
            setb(b);
            setb(4'b0000);
            idle(1);
        end
        idle(5);
        chk("sat_moves", moves_seen - mv, 260);
`ifdef MOVE_COUNT_EN
        chk("sat_count", {24'd0, move_count}, 255);
`endif

        // death with two moves queued
        mv = moves_seen; ls = lost_seen;
        setb(4'b0001); setb(4'b0100); setb(4'b0010);
        {n_btn, s_btn, e_btn, w_btn} = 4'b0000;
        d = 1'b1;
        @(negedge clk);
        d = 1'b0;
        chk("t5_game_over", {31'd0, game_over}, 1);
        setb(4'b1000); setb(4'b0000);
        idle(8);
        chk("t5_moves", moves_seen - mv, 1);
        chk("t5_lost", lost_seen - ls, 0);
        chk("t5_sticky", {31'd0, game_over}, 1);
        chk("t5_busy", {31'd0, busy}, 0);
`ifdef MOVE_COUNT_EN
        chk("t5_count_hold", {24'd0, move_count}, 255);
`endif
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_game_over", {31'd0, game_over}, 0);
        idle(2);

        // reset during GAP with queued moves
        mv = moves_seen;
        setb(4'b1000); setb(4'b0100); setb(4'b0010);
        {n_btn, s_btn, e_btn, w_btn} = 4'b0000;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("t6_outs", {28'd0, n, s, e, w}, 0);
        chk("t6_busy", {31'd0, busy}, 0);
        idle(10);
        chk("t6_moves", moves_seen - mv, 1);
        chk("t6_busy_late", {31'd0, busy}, 0);
`ifdef MOVE_COUNT_EN
        chk("t6_count", {24'd0, move_count}, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
